updown_cnt_ctrl: RTL and testbench

- Button-driven run/stop/clear control and 0–9999 counter.
- Produces the 14-bit count value consumed by the 7-segment display controller (`cnt_data` input).
- Replaces a free-running divided-clock counter: everything runs on the single system clock, with an internal tick enable.
- Raw push-buttons are synchronised, debounced and edge-detected on-chip.

---
 rtl/updown_cnt_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_updown_cnt_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_cnt_ctrl.sv
// updown_cnt_ctrl: push-button run/stop/clear control for a 0..9999 counter.
// Each raw button goes through a 2-FF synchroniser, a debouncer and an edge
// detector. Counting is paced by an internal tick enable on the system clock.
// Optional feature macro: UPDOWN_MODE_EN (adds btn_mode and down counting).

module updown_cnt_btn_path #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    // The counter only has to reach DEBOUNCE_CYC-1 before the level flips.
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic          deb_lvl;
    logic          deb_dly;
    logic [CW-1:0] deb_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b0;
        end else if (sync2 == deb_lvl) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_LAST) begin
            deb_cnt <= '0;
            deb_lvl <= sync2;
        end else begin
            deb_cnt <= deb_cnt + CNT_ONE;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_dly <= 1'b0;
        end else begin
            deb_dly <= deb_lvl;
        end
    end

    assign press = deb_lvl & ~deb_dly;

endmodule

module updown_cnt_ctrl #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int TICK_HZ      = 10,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_clear,
    input  logic        btn_mode,
    output logic [13:0] cnt,
    output logic        o_run,
    output logic        o_dir
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [13:0]      CNT_MAX  = 14'd9999;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic             run_p;
    logic             clear_p;
    logic             dir_q;
    logic             run_q;
    logic             tick;
    logic [DIV_W-1:0] div_q;
    logic [13:0]      cnt_q;

    updown_cnt_btn_path #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_path (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_run),
        .press (run_p)
    );

    updown_cnt_btn_path #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear_path (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .press (clear_p)
    );

`ifdef UPDOWN_MODE_EN
    logic mode_p;

    updown_cnt_btn_path #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_path (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .press (mode_p)
    );

    // Each mode press flips the direction, whatever the run state.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else if (mode_p) begin
            dir_q <= ~dir_q;
        end
    end
`else
    logic unused_btn_mode;
    assign unused_btn_mode = btn_mode;
    assign dir_q           = 1'b0;
`endif

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STOP;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; a clear press outranks a simultaneous run press.
    always_comb begin
        state_n = state_q;
        case (state_q)
            STOP: begin
                if (clear_p) begin
                    state_n = CLEAR;
                end else if (run_p) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (clear_p) begin
                    state_n = CLEAR;
                end else if (run_p) begin
                    state_n = STOP;
                end
            end
            CLEAR:   state_n = STOP;
            default: state_n = STOP;
        endcase
    end

    // Registered run indicator, aligned with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= (state_n == RUN);
        end
    end

    // Tick divider: advances only in RUN, holds its phase while stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (state_q == CLEAR) begin
            div_q <= '0;
        end else if (state_q == RUN) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_ONE;
            end
        end
    end

    // A pending clear suppresses a coinciding tick so the count goes straight to 0.
    assign tick = (state_q == RUN) && (div_q == DIV_LAST) && !clear_p;

    // Count register with wrap-around in both directions.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= '0;
        end else if (tick) begin
            if (dir_q) begin
                cnt_q <= (cnt_q == 14'd0) ? CNT_MAX : cnt_q - 14'd1;
            end else begin
                cnt_q <= (cnt_q == CNT_MAX) ? 14'd0 : cnt_q + 14'd1;
            end
        end
    end

    assign cnt   = cnt_q;
    assign o_run = run_q;
    assign o_dir = dir_q;

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// tb_updown_cnt_ctrl: directed self-checking bench for updown_cnt_ctrl.
// Main instance: DIV=10, DEBOUNCE_CYC=4. A second instance with DIV=2 is
// used to reach the 9999 -> 0 wrap in a reasonable number of cycles.

module tb_updown_cnt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_run;
    logic        btn_clear;
    logic        btn_mode;
    logic [13:0] cnt;
    logic        o_run;
    logic        o_dir;

    logic        fast_run;
    logic        fast_clear;
    logic        fast_mode;
    logic [13:0] fast_cnt;
    logic        fast_o_run;
    logic        fast_o_dir;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    updown_cnt_ctrl #(
        .CLK_FREQ     (100),
        .TICK_HZ      (10),
        .DEBOUNCE_CYC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .btn_mode  (btn_mode),
        .cnt       (cnt),
        .o_run     (o_run),
        .o_dir     (o_dir)
    );

    updown_cnt_ctrl #(
        .CLK_FREQ     (2),
        .TICK_HZ      (1),
        .DEBOUNCE_CYC (4)
    ) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (fast_run),
        .btn_clear (fast_clear),
        .btn_mode  (fast_mode),
        .cnt       (fast_cnt),
        .o_run     (fast_o_run),
        .o_dir     (fast_o_dir)
    );

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input int act, input int exp);
        num_checks++;
        if (act != exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Hold the selected main-DUT buttons for hold edges, release, wait idle edges.
    task automatic applyStimulus(input logic run, input logic clr, input logic mode,
                                 input int hold, input int idle);
        btn_run   = run;
        btn_clear = clr;
        btn_mode  = mode;
        wait_edges(hold);
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_mode  = 1'b0;
        wait_edges(idle);
    endtask

    initial begin
        rst        = 1'b1;
        btn_run    = 1'b0;
        btn_clear  = 1'b0;
        btn_mode   = 1'b0;
        fast_run   = 1'b0;
        fast_clear = 1'b0;
        fast_mode  = 1'b0;

        // Reset state, then 50 idle cycles.
        wait_edges(2);
        checkOutput("reset_cnt", cnt, 0);
        checkOutput("reset_run", o_run, 0);
        checkOutput("reset_dir", o_dir, 0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            wait_edges(1);
            checkOutput("idle_outputs", {o_run, o_dir, cnt}, 0);
        end

        // Hold run 20 cycles: RUN at edge 7, cnt=1 at 17, cnt=5 at 57.
        $display("[TB] run press and count timing");
        btn_run = 1'b1;
        wait_edges(6);
        checkOutput("run_edge6", o_run, 0);
        wait_edges(1);
        checkOutput("run_edge7", o_run, 1);
        wait_edges(9);
        checkOutput("cnt_edge16", cnt, 0);
        wait_edges(1);
        checkOutput("cnt_edge17", cnt, 1);
        wait_edges(3);
        btn_run = 1'b0;
        wait_edges(36);
        checkOutput("cnt_edge56", cnt, 4);
        wait_edges(1);
        checkOutput("cnt_edge57", cnt, 5);
        checkOutput("run_held", o_run, 1);

        // Second press stops the counter and freezes the count.
        applyStimulus(1'b1, 1'b0, 1'b0, 5, 2);
        checkOutput("stop_run", o_run, 0);
        checkOutput("stop_cnt", cnt, 5);
        wait_edges(30);
        checkOutput("frozen_cnt", cnt, 5);
        checkOutput("frozen_run", o_run, 0);

        // Clear from STOP, then a 3-cycle bounce is rejected, a 5-cycle press is accepted.
        applyStimulus(1'b0, 1'b1, 1'b0, 5, 10);
        checkOutput("clear_cnt", cnt, 0);
        checkOutput("clear_run", o_run, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3, 20);
        checkOutput("bounce_run", o_run, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5, 2);
        checkOutput("press5_run", o_run, 1);
        wait_edges(10);
        checkOutput("press5_cnt", cnt, 1);

        // Clear while running, then direction and first ticks.
        applyStimulus(1'b0, 1'b1, 1'b0, 5, 10);
        checkOutput("clear2_cnt", cnt, 0);
        checkOutput("clear2_run", o_run, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5, 2);
`ifdef UPDOWN_MODE_EN
        checkOutput("mode_dir", o_dir, 1);
`else
        checkOutput("mode_dir", o_dir, 0);
`endif
        wait_edges(10);
        applyStimulus(1'b1, 1'b0, 1'b0, 5, 2);
        checkOutput("dir_run", o_run, 1);
        wait_edges(9);
        checkOutput("dir_pre_tick", cnt, 0);
        wait_edges(1);
`ifdef UPDOWN_MODE_EN
        checkOutput("down_wrap", cnt, 9999);
        wait_edges(10);
        checkOutput("down_next", cnt, 9998);
`else
        checkOutput("up_only_first", cnt, 1);
        wait_edges(10);
        checkOutput("up_only_next", cnt, 2);
`endif

        // Clear, restore up direction, run to 37, then run+clear together.
        applyStimulus(1'b0, 1'b1, 1'b0, 5, 10);
        checkOutput("clear3_cnt", cnt, 0);
`ifdef UPDOWN_MODE_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 5, 2);
        checkOutput("mode_back_dir", o_dir, 0);
        wait_edges(10);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 5, 2);
        wait_edges(370);
        checkOutput("cnt_37", cnt, 37);
        applyStimulus(1'b1, 1'b1, 1'b0, 5, 2);
        checkOutput("both_clear_state_run", o_run, 0);
        checkOutput("both_clear_state_cnt", cnt, 37);
        wait_edges(1);
        checkOutput("both_after_cnt", cnt, 0);
        checkOutput("both_after_run", o_run, 0);
        wait_edges(20);
        checkOutput("both_stays_stop", o_run, 0);
        checkOutput("both_stays_zero", cnt, 0);

        // Run to 123, set down direction, then reset mid-RUN with run held.
        applyStimulus(1'b1, 1'b0, 1'b0, 5, 2);
        wait_edges(1230);
        checkOutput("cnt_123", cnt, 123);
`ifdef UPDOWN_MODE_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 5, 2);
        checkOutput("pre_reset_dir", o_dir, 1);
`else
        wait_edges(7);
        checkOutput("pre_reset_dir", o_dir, 0);
`endif
        checkOutput("pre_reset_cnt", cnt, 123);
        checkOutput("pre_reset_run", o_run, 1);
        rst     = 1'b1;
        btn_run = 1'b1;
        wait_edges(1);
        checkOutput("midreset_cnt", cnt, 0);
        checkOutput("midreset_run", o_run, 0);
        checkOutput("midreset_dir", o_dir, 0);
        rst = 1'b0;
        wait_edges(6);
        checkOutput("held_rst_edge6", o_run, 0);
        wait_edges(1);
        checkOutput("held_rst_edge7", o_run, 1);
        btn_run = 1'b0;

        // Fast instance: count up through 9999 and wrap to 0.
        $display("[TB] up wrap on DIV=2 instance");
        checkOutput("fast_idle_cnt", fast_cnt, 0);
        fast_run = 1'b1;
        wait_edges(5);
        fast_run = 1'b0;
        wait_edges(2);
        checkOutput("fast_run", fast_o_run, 1);
        wait_edges(2);
        checkOutput("fast_first", fast_cnt, 1);
        wait_edges(19996);
        checkOutput("fast_9999", fast_cnt, 9999);
        wait_edges(1);
        checkOutput("fast_9999_hold", fast_cnt, 9999);
        wait_edges(1);
        checkOutput("fast_wrap", fast_cnt, 0);
        wait_edges(2);
        checkOutput("fast_after_wrap", fast_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
